// File: rtl/spi_tx_ctrl.sv
// Purpose: SPI mode-0 slave transmitter that drains the FFT result buffer onto miso, MSB first.
// Latency: ss low -> word-0 MSB on miso after 3 clk (ARMED, FETCH, LOAD); 2 clk reload gap between words.
// Backpressure: none; the master paces bits with spi_clk_fall, and ss high aborts the frame back to ARMED.
// Ports: clk/n_reset; data_ready arms one frame; ss and spi_clk_fall come pre-synchronised from the
//        SPI front end; rd_en/rd_addr/rd_data read the result buffer (rd_data one clk after rd_en);
//        miso/miso_oe drive the pad; tx_ready flags armed-or-busy; done pulses once per full frame.
module spi_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  data_ready,
    input  logic                  ss,
    input  logic                  spi_clk_fall,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  tx_ready,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [3:0]            LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_reg_q, shift_reg_d;
    logic                    rd_en_q, rd_en_d;
    logic                    miso_oe_q, miso_oe_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
            rd_en_q     <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            rd_en_q     <= rd_en_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;

        case (state_q)
            S_IDLE: begin
                if (data_ready) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!ss) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // rd_data is valid here because rd_en was high during FETCH.
                shift_reg_d = rd_data;
                bit_cnt_d   = '0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (spi_clk_fall) begin
                    shift_reg_d = {shift_reg_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Last word stays at its address: no read is ever issued past NUM_WORDS-1.
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = S_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + ADDR_WIDTH'(1);
                            state_d    = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                word_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Master deselected mid-frame: drop back to ARMED and restart from word 0 on the next select.
        if (ss && (state_q == S_FETCH || state_q == S_LOAD || state_q == S_SHIFT)) begin
            state_d    = S_ARMED;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_comb begin
        rd_en_d   = (state_d == S_FETCH);
        miso_oe_d = !ss && (state_d == S_FETCH || state_d == S_LOAD || state_d == S_SHIFT);
    end

    assign rd_en    = rd_en_q;
    assign miso_oe  = miso_oe_q;
    assign rd_addr  = word_cnt_q;
    assign miso     = (state_q == S_LOAD || state_q == S_SHIFT) && shift_reg_q[DATA_WIDTH-1];
    assign tx_ready = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: doc/spi_tx_ctrl.md
Name: spi_tx_ctrl

Overview:
- SPI slave transmit controller for the FFT chip; the outbound counterpart of the SPI receive path that feeds the load buffer.
- After the magnitude block has filled its result buffer, this block reads it word by word and shifts each word out on miso, MSB first.
- Uses SPI mode 0: the master samples on the spi_clk rising edge, and this block changes miso on the falling edge.
- Runs on the system clock and uses the already-synchronised spi_clk_fall strobe and ss level produced by the SPI front end.

Parameters:
- DATA_WIDTH, 8, bits per transmitted word.
- NUM_WORDS, 64, number of result words sent per frame.
- ADDR_WIDTH, 6, result buffer address width; must satisfy 2^ADDR_WIDTH >= NUM_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  reset, asynchronous, active-low.
- data_ready  input  1  one-cycle pulse from the magnitude block: result buffer is complete.
- ss  input  1  synchronised slave select, active-low.
- spi_clk_fall  input  1  one-cycle strobe on each synchronised spi_clk falling edge.
- rd_data  input  DATA_WIDTH  result buffer read data; valid one clk after rd_en.
- rd_en  output  1  result buffer read strobe.
- rd_addr  output  ADDR_WIDTH  result buffer read address.
- miso  output  1  serial data out.
- miso_oe  output  1  pad output enable for miso.
- tx_ready  output  1  frame armed or in progress.
- done  output  1  one-cycle pulse when the full frame has been sent.

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (n_reset).
- Reset values: state=IDLE; word_cnt=0; bit_cnt=0; shift_reg=0; and all of rd_en, rd_addr, miso, miso_oe, tx_ready and done are 0.
- Registers: word_cnt[ADDR_WIDTH-1:0], bit_cnt[3:0] (counts falling edges within a word), shift_reg[DATA_WIDTH-1:0].
- Output decoding: all outputs are registered or decoded from state only; none are combinational from inputs.
- miso = shift_reg[DATA_WIDTH-1] in LOAD and SHIFT; 0 otherwise.
- miso_oe = !ss && state in {FETCH, LOAD, SHIFT}.
- rd_addr = word_cnt.
- tx_ready = 1 in every state except IDLE.
- States and transitions:
  - IDLE: on data_ready go to ARMED.
  - ARMED: while ss==0 go to FETCH.
  - FETCH: assert rd_en for exactly 1 cycle; next state LOAD.
  - LOAD: shift_reg <= rd_data; bit_cnt <= 0; next state SHIFT.
  - SHIFT: on spi_clk_fall, shift_reg <= {shift_reg[DATA_WIDTH-2:0],1'b0} and bit_cnt++.
    - On the DATA_WIDTH-th fall of a word: if word_cnt==NUM_WORDS-1, go to DONE; otherwise word_cnt++ and go to FETCH.
  - DONE: done=1 for 1 cycle; word_cnt <= 0; next state IDLE.
- Latency: ss falling to the MSB valid on miso is 3 clk cycles (ARMED, FETCH, LOAD).
- Inter-word gap: 2 clk cycles (FETCH, LOAD) after the last falling edge of a word; the next MSB is valid before the next spi_clk rising edge.
- Clock ratio: requires clk >= 8x the spi_clk frequency.
- Boundary conditions:
  - ss goes high in FETCH, LOAD or SHIFT: abort. Go to ARMED, clear word_cnt and bit_cnt, and drop miso_oe the next cycle. The frame restarts from word 0 on the next ss low.
  - spi_clk_fall while ss==1: ignored.
  - spi_clk_fall in FETCH or LOAD: ignored. This is only possible if the clock-ratio rule is violated.
  - data_ready in any state other than IDLE: ignored; no re-arm and no counter change.
  - data_ready coincident with reset: reset wins.
  - Last word: no rd_en is issued for address NUM_WORDS, and rd_addr never exceeds NUM_WORDS-1.
  - Reset asserted mid-frame: all registers return to reset values immediately, asynchronously; miso and miso_oe go to 0.

Test Plan:
- Reset: hold n_reset=0 while driving data_ready and ss=0 -> miso=0, miso_oe=0, tx_ready=0, rd_en=0, done=0.
- Single frame: pulse data_ready; buffer word k = k+8'h10; ss=0; apply 64x8 spi_clk_fall strobes 10 clk apart. Required response:
  - master-sampled stream is 8'h10, 8'h11 ... 8'h4F, MSB first;
  - rd_addr steps 0..63 with exactly 64 rd_en pulses;
  - done pulses once; tx_ready then returns to 0.
- Latency: ss falls 2 cycles after data_ready -> rd_en on cycle +1; miso = bit 7 of word 0 (value 0 for 8'h10) and miso_oe=1 by cycle +3.
- Abort: raise ss after 3 bits of word 5 -> miso_oe=0 next cycle and state ARMED. On the next ss low, rd_addr=0 and the stream restarts at 8'h10; done pulses only after a full 64-word frame.
- Spurious inputs: data_ready pulsed mid-frame and spi_clk_fall pulsed with ss=1 -> word_cnt, bit_cnt and output stream unchanged.
- Reset mid-word 30: assert n_reset=0 -> miso=0, tx_ready=0 asynchronously. After release, a new data_ready starts again from rd_addr=0.
